// File: rtl/fir_out_pkg.sv
// fir_out_pkg: shared defaults, level-width helper and round/saturate function for the FIR output stage
package fir_out_pkg;
  localparam int DEF_IN_W = 16;
  localparam int DEF_OUT_W = 8;
  localparam int DEF_SHIFT = 8;
  typedef struct packed {
    logic        sat;
    logic [31:0] data;
  } rs_t;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  // One extra bit on the sum keeps the rounding carry out of the top word
  function automatic rs_t round_sat(input logic [31:0] y, input int shift, input int out_w);
    rs_t o;
    logic [32:0] s;
    logic [32:0] r;
    logic [32:0] mx;
    s = {1'b0, y} + (33'd1 << (shift - 1));
    r = s >> shift;
    mx = (33'd1 << out_w) - 33'd1;
    o.sat = r > mx;
    o.data = o.sat ? mx[31:0] : r[31:0];
    return o;
  endfunction
endpackage

// File: rtl/fir_out_if.sv
// fir_out_if: valid/ready sample stream from the output stage to the sink
interface fir_out_if import fir_out_pkg::*; #(
  parameter int OUT_W = DEF_OUT_W
);
  logic [OUT_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  modport master(output m_data, m_valid, input m_ready);
  modport slave(input m_data, m_valid, output m_ready);
endinterface

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: show-ahead FIFO with occupancy tracking; head is masked to zero while empty
module fir_out_fifo import fir_out_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  logic                      i_pop,
  input  logic [WIDTH-1:0]          i_din,
  output logic [WIDTH-1:0]          o_dout,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [lvl_w(DEPTH)-1:0]   o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = lvl_w(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LW-1:0]    r_lvl;
  logic             w_wr;
  logic             w_rd;
  assign o_full  = r_lvl == LW'(DEPTH);
  assign o_empty = r_lvl == '0;
  // A push into a full FIFO is accepted only when the head leaves in the same cycle
  assign w_wr    = i_push && (!o_full || i_pop);
  assign w_rd    = i_pop && !o_empty;
  assign o_dout  = o_empty ? '0 : r_mem[r_rp];
  assign o_level = r_lvl;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      r_wp  <= r_wp + AW'(w_wr);
      r_rp  <= r_rp + AW'(w_rd);
      r_lvl <= r_lvl + LW'(w_wr) - LW'(w_rd);
    end
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wp] <= i_din;
endmodule

// File: rtl/fir_out_stage.sv
// fir_out_stage: aligns, rounds/saturates and buffers FIR output words behind a valid/ready port
module fir_out_stage import fir_out_pkg::*; #(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int SHIFT = DEF_SHIFT,
  parameter int LAT   = 1,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    x_valid,
  input  logic [IN_W-1:0]         yin,
  input  logic                    clr_stats,
  fir_out_if.master               m,
  output logic                    overflow,
  output logic [7:0]              sat_count,
  output logic [lvl_w(DEPTH)-1:0] level
);
  logic [LAT-1:0]   r_dl;
  logic [OUT_W-1:0] r_rs_data;
  logic             r_rs_valid;
  logic             r_rs_sat;
  rs_t              w_rs;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  assign w_rs      = round_sat(32'(yin), SHIFT, OUT_W);
  assign w_pop     = m.m_valid && m.m_ready;
  assign m.m_valid = !w_empty;
  // The oldest delay-line bit marks the cycle in which yin belongs to a real sample
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dl       <= '0;
      r_rs_valid <= 1'b0;
      r_rs_sat   <= 1'b0;
      r_rs_data  <= '0;
    end else begin
      r_dl       <= LAT'({r_dl, x_valid});
      r_rs_valid <= r_dl[LAT-1];
      r_rs_sat   <= r_dl[LAT-1] && w_rs.sat;
      r_rs_data  <= OUT_W'(w_rs.data);
    end
  end
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      overflow  <= 1'b0;
      sat_count <= '0;
    end else begin
      overflow  <= overflow | (r_rs_valid && w_full && !w_pop);
      sat_count <= sat_count + 8'(r_rs_valid && r_rs_sat && sat_count != 8'hFF);
    end
  end
  fir_out_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rs_valid),
    .i_pop   (w_pop),
    .i_din   (r_rs_data),
    .o_dout  (m.m_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );
endmodule

// File: tb/tb_fir_out_stage.sv
// tb_fir_out_stage: table vectors, directed corner sequences and randomized run against a queue-based model
module tb_fir_out_stage;
  import fir_out_pkg::*;
  localparam int LAT = 1;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst;
  logic        x_valid;
  logic        clr_stats;
  logic [15:0] yin;
  logic        overflow;
  logic [7:0]  sat_count;
  logic [2:0]  level;
  fir_out_if #(.OUT_W(8)) bus ();
  fir_out_stage #(.IN_W(16), .OUT_W(8), .SHIFT(8), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_valid   (x_valid),
    .yin       (yin),
    .clr_stats (clr_stats),
    .m         (bus),
    .overflow  (overflow),
    .sat_count (sat_count),
    .level     (level)
  );
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_pass = 0;
  // Model state: delivered-sample queue, alignment queue, pending rounded sample, stats
  byte unsigned mq[$];
  bit           dl[$];
  bit           ovf;
  int           satc;
  bit           pv;
  bit           ps;
  int           pd;
  typedef struct {
    logic [15:0] y;
    logic [7:0]  d;
    logic [7:0]  sat;
  } vec_t;
  vec_t tbl[8];
  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  function automatic void rnd(input int y, output int d, output bit s);
    int r;
    r = (y + 128) / 256;
    s = r > 255;
    d = s ? 255 : r;
  endfunction
  task automatic model_edge(input bit r, input bit xv, input bit rdy, input bit clr, input int y);
    bit pop;
    bit full;
    bit tag;
    int d;
    bit s;
    if (r) begin
      mq.delete();
      dl.delete();
      repeat (LAT) dl.push_back(1'b0);
      ovf = 0;
      satc = 0;
      pv = 0;
      ps = 0;
      pd = 0;
    end else begin
      pop = mq.size() > 0 && rdy;
      full = mq.size() == DEPTH;
      if (clr) begin
        ovf = 0;
        satc = 0;
      end else begin
        if (pv && full && !pop) ovf = 1;
        if (pv && ps && satc < 255) satc++;
      end
      if (pop) void'(mq.pop_front());
      if (pv && (!full || pop)) mq.push_back(byte'(pd));
      tag = dl.pop_front();
      dl.push_back(xv);
      rnd(y, d, s);
      pv = tag;
      ps = s;
      pd = d;
    end
  endtask
  task automatic step(input bit xv, input int y, input bit rdy, input bit clr, input bit r = 1'b0);
    rst = r;
    x_valid = xv;
    yin = 16'(y);
    bus.m_ready = rdy;
    clr_stats = clr;
    model_edge(r, xv, rdy, clr, y & 32'hFFFF);
    @(posedge clk);
    #1;
    chk("m_valid", int'(bus.m_valid), int'(mq.size() > 0));
    chk("level", int'(level), mq.size());
    if (mq.size() > 0) chk("m_data", int'(bus.m_data), int'(mq[0]));
    chk("overflow", int'(overflow), int'(ovf));
    chk("sat_count", int'(sat_count), satc);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    tbl[0] = '{16'h127F, 8'h12, 8'd0};
    tbl[1] = '{16'h1280, 8'h13, 8'd0};
    tbl[2] = '{16'hFF7F, 8'hFF, 8'd0};
    tbl[3] = '{16'hFF80, 8'hFF, 8'd1};
    tbl[4] = '{16'h0000, 8'h00, 8'd0};
    tbl[5] = '{16'hFFFF, 8'hFF, 8'd1};
    tbl[6] = '{16'h00FF, 8'h01, 8'd0};
    tbl[7] = '{16'h007F, 8'h00, 8'd0};
    step(0, 0, 0, 0, 1);
    chk("rst_m_data", int'(bus.m_data), 0);
    chk("rst_level", int'(level), 0);
    foreach (tbl[i]) begin
      step(0, 0, 0, 0, 1);
      step(1, tbl[i].y, 0, 0);
      step(0, tbl[i].y, 0, 0);
      chk("latency_not_yet", int'(bus.m_valid), 0);
      step(0, tbl[i].y, 0, 0);
      chk("tbl_valid", int'(bus.m_valid), 1);
      chk("tbl_data", int'(bus.m_data), int'(tbl[i].d));
      chk("tbl_sat", int'(sat_count), int'(tbl[i].sat));
      step(0, 0, 1, 0);
      chk("tbl_popped", int'(level), 0);
    end
    step(0, 0, 0, 0, 1);
    for (int s = 0; s < 9; s++) step(s < 6, s * 256, 0, 0);
    chk("ovf_level", int'(level), 4);
    chk("ovf_flag", int'(overflow), 1);
    for (int k = 1; k <= 4; k++) begin
      chk("ovf_drain", int'(bus.m_data), k);
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 1);
    chk("clr_ovf", int'(overflow), 0);
    chk("clr_sat", int'(sat_count), 0);
    step(0, 0, 0, 0, 1);
    for (int s = 0; s < 7; s++) step(s < 5, s * 256, s == 6, 0);
    chk("pp_level", int'(level), 4);
    chk("pp_ovf", int'(overflow), 0);
    for (int k = 2; k <= 5; k++) begin
      chk("pp_order", int'(bus.m_data), k);
      step(0, 0, 1, 0);
    end
    step(0, 0, 0, 0, 1);
    for (int s = 0; s < 22; s++) begin
      step(1, s * 16'h0311, 1, 0);
      chk("ramp_level_le1", int'(level <= 1), 1);
      if (s >= 2) chk("ramp_valid", int'(bus.m_valid), 1);
    end
    step(0, 0, 0, 0, 1);
    for (int s = 0; s < 5; s++) step(1, (s + 1) * 256, 0, 0);
    chk("pre_rst_level", int'(level), 3);
    step(0, 0, 0, 0, 1);
    chk("rst_mid_valid", int'(bus.m_valid), 0);
    chk("rst_mid_level", int'(level), 0);
    for (int s = 0; s < 6; s++) begin
      step(0, 16'h4000, 1, 0);
      chk("no_stale", int'(bus.m_valid), 0);
    end
    step(0, 0, 0, 0, 1);
    for (int s = 0; s < 262; s++) step(1, 16'hFFFF, 1, 0);
    chk("sat_hold", int'(sat_count), 255);
    step(0, 0, 0, 1);
    for (int s = 0; s < 600; s++)
      step(bit'($urandom_range(0, 2) != 0), int'($urandom_range(0, 65535)),
           bit'($urandom_range(0, 1)), $urandom_range(0, 19) == 0, $urandom_range(0, 99) == 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fir_out_stage.md
# fir_out_stage

Downstream consumer of the 3-tap FIR filter: captures the filter's registered 16-bit output, tags it valid using a delayed copy of the input-sample strobe, rounds and saturates it to 8 bits, and buffers results in a small FIFO behind a valid/ready output port. It decouples the free-running filter from a back-pressuring sink (DAC serializer or bus bridge) and counts overflow and saturation events.

## Interface
Parameters:
- IN_W, 16, width of filter output word (unsigned).
- OUT_W, 8, width of delivered sample.
- SHIFT, 8, right-shift applied after rounding; must satisfy 1 ≤ SHIFT < IN_W.
- LAT, 1, cycles from filter input sample to its registered output; must be ≥ 1.
- DEPTH, 4, FIFO entries; power of two.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- x_valid  in  1  high in the cycle a new Xin is presented to the filter.
- yin  in  IN_W  filter output word (registered in the filter).
- m_data  out  OUT_W  head-of-FIFO sample.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  sink accepts m_data when m_valid && m_ready.
- clr_stats  in  1  synchronous clear of overflow and sat_count.
- overflow  out  1  sticky; a sample was dropped because the FIFO was full.
- sat_count  out  8  number of saturated samples, holds at 255.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- Alignment: x_valid passes through a LAT-stage shift register; its output (tag) qualifies yin in the same cycle.
- Round stage (registered): when tag=1, r = (yin + 2^(SHIFT-1)) >> SHIFT using an IN_W+1-bit sum; if r > 2^OUT_W − 1, output 2^OUT_W − 1 and flag sat, else r[OUT_W-1:0]. Stage register holds rs_data, rs_valid, rs_sat.
- Push: rs_valid=1 pushes rs_data. pop = m_valid && m_ready.
- Full with push and no pop: sample dropped, overflow set, FIFO unchanged. Full with push and pop: both happen, level unchanged, no overflow.
- Empty with pop impossible (m_valid=0); empty with push: level 0→1.
- sat_count increments on rs_valid && rs_sat, whether or not the sample is dropped; stops at 255.
- clr_stats clears overflow and sat_count; same-cycle overflow/saturation event is ignored (clear wins).
- FIFO is show-ahead: m_data = mem[rd_ptr]; m_data is don't-care when m_valid=0 but must not be X after reset (mem cleared or masked to 0).
- Pointers wrap modulo DEPTH; level tracked with one extra bit.

## Timing
- Reset: m_valid=0, m_data=0, overflow=0, sat_count=0, level=0, delay line and rs_valid cleared. Reset mid-stream discards all buffered and in-flight samples; first tag after reset requires a fresh x_valid at least LAT cycles later.
- Latency: x_valid at edge E → yin sampled with tag at edge E+LAT → rs_valid at E+LAT → pushed at E+LAT+1 → m_valid high from cycle after E+LAT+1 (total LAT+2 edges).
- Throughput: one sample per clock when m_ready=1 continuously.
- m_valid/m_data change only on clock edges; no combinational path from m_ready to m_valid or m_data.
- overflow and sat_count update on the edge following the triggering rs_valid.

## Structure
- Package fir_out_pkg: IN_W/OUT_W/SHIFT defaults, level width helper, round_sat function (returns data and sat flag).
- Sub-module fir_out_fifo (show-ahead, parameterised WIDTH/DEPTH, push/pop/full/empty/level); top holds delay line, round stage, counters.

## Test plan
- Reset then x_valid pulse with yin=0x1280 at tag cycle → m_data=0x13 after LAT+2 edges, level=1; m_ready=1 pops next edge, level=0.
- Rounding edges: yin=0x127F → 0x12; yin=0x1280 → 0x13; yin=0xFF7F → 0xFF, no sat; yin=0xFF80 → 0xFF, sat_count=1.
- m_ready=0, 6 consecutive valid samples 0x0100..0x0600 → level=4, m_data sequence 0x01..0x04 on drain, overflow=1; then clr_stats → overflow=0, sat_count=0.
- Full FIFO, push and pop same cycle → level stays 4, overflow stays 0, order preserved.
- Continuous x_valid with m_ready=1 for 20 cycles and yin ramp → one output per cycle, in order, level ≤ 1.
- rst asserted with level=3 and tag in flight → next cycle m_valid=0, level=0; no stale sample appears afterwards.
